// File: rtl/sap_control_sequencer.sv
// Microcoded T-state sequencer for the SAP-class 8-bit CPU: fetch/execute control word decode.
// Optional feature: define SAP_SEQ_EARLY_END_EN to return to T0 right after an instruction's last non-empty step.
module sap_control_sequencer (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       clk_en_i,
    input  logic [3:0] opcode_i,
    output logic [2:0] step_o,
    output logic       halted_o,
    output logic       hlt_o,
    output logic       mi_o,
    output logic       ri_o,
    output logic       ro_o,
    output logic       io_o,
    output logic       ii_o,
    output logic       ai_o,
    output logic       ao_o,
    output logic       eo_o,
    output logic       su_o,
    output logic       bi_o,
    output logic       oi_o,
    output logic       ce_o,
    output logic       co_o,
    output logic       j_o
);

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } step_e;

    typedef struct packed {
        logic hlt;
        logic mi;
        logic ri;
        logic ro;
        logic io;
        logic ii;
        logic ai;
        logic ao;
        logic eo;
        logic su;
        logic bi;
        logic oi;
        logic ce;
        logic co;
        logic j;
    } ctrl_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    step_e step_q, step_d;
    logic  halted_q, halted_d;
    ctrl_t ctrl;

    // Execute-phase microcode; anything not listed is an all-zero word.
    function automatic ctrl_t exec_word(input logic [3:0] op, input step_e st);
        ctrl_t w;
        w = '0;
        case (op)
            OP_LDA: begin
                if (st == T2) begin w.io = 1'b1; w.mi = 1'b1; end
                if (st == T3) begin w.ro = 1'b1; w.ai = 1'b1; end
            end
            OP_ADD, OP_SUB: begin
                if (st == T2) begin w.io = 1'b1; w.mi = 1'b1; end
                if (st == T3) begin w.ro = 1'b1; w.bi = 1'b1; end
                if (st == T4) begin
                    w.eo = 1'b1;
                    w.ai = 1'b1;
                    w.su = (op == OP_SUB);
                end
            end
            OP_STA: begin
                if (st == T2) begin w.io = 1'b1; w.mi = 1'b1; end
                if (st == T3) begin w.ao = 1'b1; w.ri = 1'b1; end
            end
            OP_LDI: begin
                if (st == T2) begin w.io = 1'b1; w.ai = 1'b1; end
            end
            OP_JMP: begin
                if (st == T2) begin w.io = 1'b1; w.j = 1'b1; end
            end
            OP_OUT: begin
                if (st == T2) begin w.ao = 1'b1; w.oi = 1'b1; end
            end
            OP_HLT: begin
                if (st == T2) w.hlt = 1'b1;
            end
            default: w = '0;
        endcase
        return w;
    endfunction

`ifdef SAP_SEQ_EARLY_END_EN
    // Last step that carries a non-empty word. The NOP decision at T1 necessarily
    // uses the opcode presented during T1, since that is the only chance to cut it short.
    function automatic step_e last_step(input logic [3:0] op);
        step_e s;
        case (op)
            OP_LDI, OP_JMP, OP_OUT: s = T2;
            OP_LDA, OP_STA:         s = T3;
            OP_ADD, OP_SUB, OP_HLT: s = T4;
            default:                s = T1;
        endcase
        return s;
    endfunction
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            step_q   <= T0;
            halted_q <= 1'b0;
        end else begin
            step_q   <= step_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        step_d   = step_q;
        halted_d = halted_q;
        if (clk_en_i && !halted_q) begin
            if (step_q == T2 && opcode_i == OP_HLT) begin
                halted_d = 1'b1;
            end else begin
                case (step_q)
                    T0: step_d = T1;
                    T1: step_d = T2;
                    T2: step_d = T3;
                    T3: step_d = T4;
                    default: step_d = T0;
                endcase
`ifdef SAP_SEQ_EARLY_END_EN
                if (step_q == last_step(opcode_i)) step_d = T0;
`endif
            end
        end
    end

    always_comb begin
        ctrl = '0;
        if (halted_q) begin
            ctrl.hlt = 1'b1;
        end else begin
            case (step_q)
                T0: begin
                    ctrl.co = 1'b1;
                    ctrl.mi = 1'b1;
                end
                T1: begin
                    ctrl.ro = 1'b1;
                    ctrl.ii = 1'b1;
                    ctrl.ce = 1'b1;
                end
                default: ctrl = exec_word(opcode_i, step_q);
            endcase
        end
    end

    assign step_o   = step_q;
    assign halted_o = halted_q;
    assign hlt_o    = ctrl.hlt;
    assign mi_o     = ctrl.mi;
    assign ri_o     = ctrl.ri;
    assign ro_o     = ctrl.ro;
    assign io_o     = ctrl.io;
    assign ii_o     = ctrl.ii;
    assign ai_o     = ctrl.ai;
    assign ao_o     = ctrl.ao;
    assign eo_o     = ctrl.eo;
    assign su_o     = ctrl.su;
    assign bi_o     = ctrl.bi;
    assign oi_o     = ctrl.oi;
    assign ce_o     = ctrl.ce;
    assign co_o     = ctrl.co;
    assign j_o      = ctrl.j;

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Directed, table-driven bench for sap_control_sequencer: fetch/execute words, halt, clk_en hold and instruction lengths.
module tb_sap_control_sequencer;

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic       clk_en_i;
    logic [3:0] opcode_i;
    logic [2:0] step_o;
    logic       halted_o, hlt_o, mi_o, ri_o, ro_o, io_o, ii_o, ai_o, ao_o;
    logic       eo_o, su_o, bi_o, oi_o, ce_o, co_o, j_o;

    sap_control_sequencer dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .clk_en_i(clk_en_i), .opcode_i(opcode_i),
        .step_o(step_o), .halted_o(halted_o), .hlt_o(hlt_o), .mi_o(mi_o), .ri_o(ri_o),
        .ro_o(ro_o), .io_o(io_o), .ii_o(ii_o), .ai_o(ai_o), .ao_o(ao_o), .eo_o(eo_o),
        .su_o(su_o), .bi_o(bi_o), .oi_o(oi_o), .ce_o(ce_o), .co_o(co_o), .j_o(j_o)
    );

    always #5 clk_i = ~clk_i;

    localparam logic [14:0] HLT = 15'h4000, MI = 15'h2000, RI = 15'h1000, RO = 15'h0800;
    localparam logic [14:0] IO  = 15'h0400, II = 15'h0200, AI = 15'h0100, AO = 15'h0080;
    localparam logic [14:0] EO  = 15'h0040, SU = 15'h0020, BI = 15'h0010, OI = 15'h0008;
    localparam logic [14:0] CE  = 15'h0004, CO = 15'h0002, J  = 15'h0001;
    localparam logic [14:0] W_T0 = CO | MI;
    localparam logic [14:0] W_T1 = RO | II | CE;

    logic [14:0] act_word;
    assign act_word = {hlt_o, mi_o, ri_o, ro_o, io_o, ii_o, ai_o, ao_o,
                       eo_o, su_o, bi_o, oi_o, ce_o, co_o, j_o};

    typedef struct packed {
        logic        rst_n;
        logic        en;
        logic [3:0]  op;
        logic [2:0]  step;
        logic        halted;
        logic [14:0] word;
    } vec_t;

    vec_t tbl [0:14];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [2:0] es, input logic eh,
                         input logic [14:0] ew);
        n_vec++;
        if (step_o !== es || halted_o !== eh || act_word !== ew) begin
            n_err++;
            $display("FAIL %s: got step=%0d halted=%0b word=%h, expected step=%0d halted=%0b word=%h",
                     name, step_o, halted_o, act_word, es, eh, ew);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // From T0, apply op and count enabled edges until T0 recurs.
    task automatic run_len(input string name, input logic [3:0] op, input int exp_len);
        int n;
        n = 0;
        opcode_i = op;
        do begin
            tick();
            n++;
        end while (step_o != 3'd0 && n < 12);
        n_vec++;
        if (n != exp_len) begin
            n_err++;
            $display("FAIL %s: got length=%0d, expected length=%0d", name, n, exp_len);
        end
    endtask

    initial begin
        // {rst_n, en, op, exp step, exp halted, exp word} after one edge
        tbl[0]  = '{1'b1, 1'b1, 4'h2, 3'd1, 1'b0, W_T1};
        tbl[1]  = '{1'b1, 1'b1, 4'h2, 3'd2, 1'b0, IO | MI};
        tbl[2]  = '{1'b1, 1'b1, 4'h2, 3'd3, 1'b0, RO | BI};
        tbl[3]  = '{1'b1, 1'b1, 4'h2, 3'd4, 1'b0, EO | AI};
        tbl[4]  = '{1'b1, 1'b1, 4'h3, 3'd0, 1'b0, W_T0};
        tbl[5]  = '{1'b1, 1'b1, 4'h3, 3'd1, 1'b0, W_T1};
        tbl[6]  = '{1'b1, 1'b1, 4'h3, 3'd2, 1'b0, IO | MI};
        tbl[7]  = '{1'b1, 1'b1, 4'h3, 3'd3, 1'b0, RO | BI};
        tbl[8]  = '{1'b1, 1'b1, 4'h3, 3'd4, 1'b0, EO | AI | SU};
        tbl[9]  = '{1'b1, 1'b1, 4'hF, 3'd0, 1'b0, W_T0};
        tbl[10] = '{1'b1, 1'b1, 4'hF, 3'd1, 1'b0, W_T1};
        tbl[11] = '{1'b1, 1'b1, 4'hF, 3'd2, 1'b0, HLT};
        tbl[12] = '{1'b1, 1'b1, 4'hF, 3'd2, 1'b1, HLT};
        tbl[13] = '{1'b1, 1'b1, 4'h2, 3'd2, 1'b1, HLT};
        tbl[14] = '{1'b1, 1'b0, 4'h3, 3'd2, 1'b1, HLT};

        rst_n_i  = 1'b0;
        clk_en_i = 1'b1;
        opcode_i = 4'h2;
        #1;
        check("reset_async", 3'd0, 1'b0, W_T0);
        tick();
        tick();
        check("reset_held", 3'd0, 1'b0, W_T0);
        rst_n_i = 1'b1;
        #1;
        check("reset_release", 3'd0, 1'b0, W_T0);

        for (int i = 0; i < 15; i++) begin
            rst_n_i  = tbl[i].rst_n;
            clk_en_i = tbl[i].en;
            opcode_i = tbl[i].op;
            tick();
            check($sformatf("vec%0d", i), tbl[i].step, tbl[i].halted, tbl[i].word);
        end

        clk_en_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("halt_hold%0d", i), 3'd2, 1'b1, HLT);
        end
        #2 rst_n_i = 1'b0;
        #1;
        check("halt_reset", 3'd0, 1'b0, W_T0);
        tick();
        rst_n_i = 1'b1;

        // LDA with clk_en low for 3 cycles at T3
        opcode_i = 4'h1;
        tick();
        check("lda_t1", 3'd1, 1'b0, W_T1);
        tick();
        check("lda_t2", 3'd2, 1'b0, IO | MI);
        tick();
        check("lda_t3", 3'd3, 1'b0, RO | AI);
        clk_en_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("lda_hold%0d", i), 3'd3, 1'b0, RO | AI);
        end
        clk_en_i = 1'b1;
        tick();
`ifdef SAP_SEQ_EARLY_END_EN
        check("lda_resume", 3'd0, 1'b0, W_T0);
`else
        check("lda_resume", 3'd4, 1'b0, 15'h0000);
        tick();
        check("lda_wrap", 3'd0, 1'b0, W_T0);
`endif

        // JMP, then live decode when the opcode changes mid-T2
        opcode_i = 4'h6;
        tick();
        tick();
        check("jmp_t2", 3'd2, 1'b0, IO | J);
        opcode_i = 4'hE;
        #1;
        check("out_t2_live", 3'd2, 1'b0, AO | OI);
        tick();
`ifdef SAP_SEQ_EARLY_END_EN
        check("out_end", 3'd0, 1'b0, W_T0);
`else
        check("out_t3", 3'd3, 1'b0, 15'h0000);
        tick();
        check("out_t4", 3'd4, 1'b0, 15'h0000);
        tick();
        check("out_wrap", 3'd0, 1'b0, W_T0);
`endif

`ifdef SAP_SEQ_EARLY_END_EN
        run_len("ldi_len", 4'h5, 3);
        run_len("nop_len", 4'h0, 2);
`else
        run_len("ldi_len", 4'h5, 5);
        run_len("nop_len", 4'h0, 5);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
